// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encoding, default phase indices and default masks
package cpu_seq_pkg;
  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam int PH_FETCH     = 0;
  localparam int PH_GETREGS   = 1;
  localparam int PH_READMEM   = 2;
  localparam int PH_WRITEBACK = 3;
  localparam logic [3:0] DEF_WAIT_MASK = 4'b1101;
  localparam logic [3:0] DEF_SKIP_MASK = 4'b0100;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_sat
);
  logic [W-1:0] r_cnt;
  assign o_cnt = r_cnt;
  assign o_sat = &r_cnt;
  // clear wins over increment; increment stops once every bit is set
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && !o_sat) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: one-hot instruction phase strobes with busy-wait, skip, flush and timeout
module cpu_phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int                  N_PHASES  = 4,
  parameter logic [N_PHASES-1:0] WAIT_MASK = N_PHASES'(DEF_WAIT_MASK),
  parameter logic [N_PHASES-1:0] SKIP_MASK = N_PHASES'(DEF_SKIP_MASK),
  parameter int                  CNT_W     = 32,
  parameter int                  TO_W      = 16,
  parameter int                  TIMEOUT   = 0,
  localparam int                 PW        = N_PHASES > 2 ? $clog2(N_PHASES) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_busy,
  input  logic                i_skip,
  input  logic                i_flush,
  output logic [N_PHASES-1:0] o_phase_oh,
  output logic [PW-1:0]       o_phase_idx,
  output logic                o_phase_first,
  output logic                o_instr_done,
  output logic                o_timeout_err,
  output logic                o_idle,
  output logic [CNT_W-1:0]    o_retired_cnt,
  output logic [CNT_W-1:0]    o_stall_cnt
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [PW-1:0]   FETCH   = PW'(PH_FETCH);

  // lowest later phase not bypassed by skip; MSB flags that one exists
  function automatic logic [PW:0] f_next(input logic [PW-1:0] p, input logic s);
    logic [PW:0] r;
    r = '0;
    for (int q = N_PHASES - 1; q > 0; q--)
      if (q > int'(p) && !(SKIP_MASK[q] && s)) r = {1'b1, PW'(q)};
    return r;
  endfunction

  state_t           r_state, w_state;
  logic [PW-1:0]    r_phase, w_phase;
  logic             r_first, w_first;
  logic             r_done, w_done;
  logic             r_terr, w_terr;
  logic [CNT_W-1:0] r_retired;
  logic             w_stall_inc, w_tmr_inc, w_tmr_clr;
  logic             w_stall_sat, w_tmr_sat;
  logic [TO_W-1:0]  w_timer;
  logic             w_blk, w_to;
  logic [PW:0]      w_nxt;

  assign w_blk = (r_state == S_RUN) && WAIT_MASK[r_phase] && i_busy;
  assign w_to  = (TIMEOUT != 0) && w_blk && (w_timer == TO_LAST);
  assign w_nxt = f_next(r_phase, i_skip);

  assign o_phase_oh    = (r_state == S_RUN) ? N_PHASES'(1) << r_phase : '0;
  assign o_phase_idx   = r_phase;
  assign o_idle        = (r_state == S_INIT);
  assign o_phase_first = r_first;
  assign o_instr_done  = r_done;
  assign o_timeout_err = r_terr;
  assign o_retired_cnt = r_retired;

  sat_counter #(.W(CNT_W)) u_stall (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_inc  (w_stall_inc && !w_stall_sat),
    .i_clr  (1'b0),
    .o_cnt  (o_stall_cnt),
    .o_sat  (w_stall_sat)
  );

  sat_counter #(.W(TO_W)) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_inc  (w_tmr_inc && !w_tmr_sat),
    .i_clr  (w_tmr_clr),
    .o_cnt  (w_timer),
    .o_sat  (w_tmr_sat)
  );

  // next state with priority flush > timeout > hold > advance/complete
  always_comb begin
    w_state     = r_state;
    w_phase     = r_phase;
    w_first     = 1'b0;
    w_done      = 1'b0;
    w_terr      = 1'b0;
    w_stall_inc = 1'b0;
    w_tmr_inc   = 1'b0;
    w_tmr_clr   = 1'b0;
    if (r_state == S_INIT) begin
      w_state = i_en ? S_RUN : S_INIT;
      w_first = i_en;
    end else if (i_flush) begin
      w_phase   = FETCH;
      w_first   = 1'b1;
      w_tmr_clr = 1'b1;
    end else if (w_to) begin
      w_phase     = FETCH;
      w_first     = 1'b1;
      w_terr      = 1'b1;
      w_stall_inc = 1'b1;
      w_tmr_clr   = 1'b1;
    end else if (w_blk) begin
      w_stall_inc = 1'b1;
      w_tmr_inc   = 1'b1;
    end else if (w_nxt[PW]) begin
      w_phase   = w_nxt[PW-1:0];
      w_first   = 1'b1;
      w_tmr_clr = 1'b1;
    end else begin
      w_state   = i_en ? S_RUN : S_INIT;
      w_phase   = FETCH;
      w_first   = i_en;
      w_done    = 1'b1;
      w_tmr_clr = 1'b1;
    end
  end

  // state, registered pulses and the wrapping retire counter
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= S_INIT;
      r_phase   <= '0;
      r_first   <= 1'b0;
      r_done    <= 1'b0;
      r_terr    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state;
      r_phase   <= w_phase;
      r_first   <= w_first;
      r_done    <= w_done;
      r_terr    <= w_terr;
      r_retired <= r_retired + CNT_W'(w_done);
    end
endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: directed scoreboard bench for the phase sequencer
module tb_cpu_phase_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0, busy = 1'b0, skip = 1'b0, flush = 1'b0;
  logic [3:0]  phase_oh;
  logic [1:0]  phase_idx;
  logic        phase_first, instr_done, timeout_err, idle;
  logic [31:0] retired_cnt, stall_cnt;

  typedef struct {
    string      tag;
    logic [3:0] oh;
    logic       first;
    logic       done;
    logic       terr;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  cpu_phase_sequencer #(.TIMEOUT(5)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_busy       (busy),
    .i_skip       (skip),
    .i_flush      (flush),
    .o_phase_oh   (phase_oh),
    .o_phase_idx  (phase_idx),
    .o_phase_first(phase_first),
    .o_instr_done (instr_done),
    .o_timeout_err(timeout_err),
    .o_idle       (idle),
    .o_retired_cnt(retired_cnt),
    .o_stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [1:0] idx;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (e.oh[i]) idx = 2'(i);
    chk({e.tag, ".oh"}, 32'(phase_oh), 32'(e.oh));
    chk({e.tag, ".idx"}, 32'(phase_idx), 32'(idx));
    chk({e.tag, ".first"}, 32'(phase_first), 32'(e.first));
    chk({e.tag, ".done"}, 32'(instr_done), 32'(e.done));
    chk({e.tag, ".terr"}, 32'(timeout_err), 32'(e.terr));
    chk({e.tag, ".idle"}, 32'(idle), 32'(e.oh == 4'd0));
  endtask

  task automatic step(input logic e, b, s, f, input logic [3:0] oh,
                      input logic fi, d, t, input string tag);
    exp_t x;
    en = e; busy = b; skip = s; flush = f;
    x.tag = tag; x.oh = oh; x.first = fi; x.done = d; x.terr = t;
    sb.push_back(x);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst.oh", 32'(phase_oh), 32'd0);
    chk("rst.idle", 32'(idle), 32'd1);
    chk("rst.first", 32'(phase_first), 32'd0);
    chk("rst.done", 32'(instr_done), 32'd0);
    chk("rst.retired", retired_cnt, 32'd0);
    chk("rst.stall", stall_cnt, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 0, 0, 0, 4'b0000, 0, 0, 0, "init_hold");
    step(1, 0, 0, 0, 4'b0001, 1, 0, 0, "init_go");
    // free run: three full instructions
    for (int i = 0; i < 12; i++)
      step(1, 0, 0, 0, 4'(1 << ((i + 1) % 4)), 1, (i % 4) == 3, 0, $sformatf("run%0d", i));
    chk("t1.retired", retired_cnt, 32'd3);
    // busy in phase 1 has no effect, busy in phase 2 holds 3 cycles
    step(1, 0, 0, 0, 4'b0010, 1, 0, 0, "t2.p1");
    step(1, 1, 0, 0, 4'b0100, 1, 0, 0, "t2.p1busy");
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 4'b0100, 0, 0, 0, $sformatf("t2.hold%0d", i));
    step(1, 0, 0, 0, 4'b1000, 1, 0, 0, "t2.p3");
    chk("t2.stall", stall_cnt, 32'd3);
    step(1, 0, 0, 0, 4'b0001, 1, 1, 0, "t2.done");
    // skip at phase 1 advance bypasses phase 2; skip in phase 3 is inert
    step(1, 0, 1, 0, 4'b0010, 1, 0, 0, "t3.p0skip");
    step(1, 0, 1, 0, 4'b1000, 1, 0, 0, "t3.skip2");
    step(1, 0, 1, 0, 4'b0001, 1, 1, 0, "t3.done");
    chk("t3.retired", retired_cnt, 32'd5);
    // busy-wait timeout in fetch
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 4'b0001, 0, 0, 0, $sformatf("t4.hold%0d", i));
    step(1, 1, 0, 0, 4'b0001, 1, 0, 1, "t4.timeout");
    chk("t4.retired", retired_cnt, 32'd5);
    chk("t4.stall", stall_cnt, 32'd8);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 4'b0001, 0, 0, 0, $sformatf("t4.rehold%0d", i));
    step(1, 0, 0, 0, 4'b0010, 1, 0, 0, "t4.resume");
    chk("t4.stall2", stall_cnt, 32'd12);
    // flush in phase 3 while busy, then flush colliding with timeout
    step(1, 0, 0, 0, 4'b0100, 1, 0, 0, "t5.p2");
    step(1, 0, 0, 0, 4'b1000, 1, 0, 0, "t5.p3");
    step(1, 1, 0, 1, 4'b0001, 1, 0, 0, "t5.flush");
    chk("t5.stall", stall_cnt, 32'd12);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 4'b0001, 0, 0, 0, $sformatf("t5.hold%0d", i));
    step(1, 1, 0, 1, 4'b0001, 1, 0, 0, "t5.flush_to");
    chk("t5.stall2", stall_cnt, 32'd16);
    chk("t5.retired", retired_cnt, 32'd5);
    step(1, 0, 0, 0, 4'b0010, 1, 0, 0, "t5.resume");
    // drop en mid-instruction: finish, park, ignore flush in INIT
    step(0, 0, 0, 0, 4'b0100, 1, 0, 0, "t6.p2");
    step(0, 0, 0, 0, 4'b1000, 1, 0, 0, "t6.p3");
    step(0, 0, 0, 0, 4'b0000, 0, 1, 0, "t6.park");
    step(0, 0, 0, 1, 4'b0000, 0, 0, 0, "t6.init_flush");
    chk("t6.retired", retired_cnt, 32'd6);
    step(1, 0, 0, 0, 4'b0001, 1, 0, 0, "t6.restart");
    step(1, 0, 0, 0, 4'b0010, 1, 0, 0, "t6.p1");
    step(1, 0, 0, 0, 4'b0100, 1, 0, 0, "t6.p2b");
    // asynchronous reset mid phase 2
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst.oh", 32'(phase_oh), 32'd0);
    chk("t6.rst.idle", 32'(idle), 32'd1);
    chk("t6.rst.first", 32'(phase_first), 32'd0);
    chk("t6.rst.idx", 32'(phase_idx), 32'd0);
    chk("t6.rst.retired", retired_cnt, 32'd0);
    chk("t6.rst.stall", stall_cnt, 32'd0);
    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
